seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 24 ++
 rtl/seq_alu.sv | 156 +++++++++++++++
 tb/tb_seq_alu.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response bundle between an ALU client and seq_alu
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             div_zero;

  modport master (
    output start, alu_op, src_a, src_b,
    input  busy, done, result, zero, div_zero
  );

  modport slave (
    input  start, alu_op, src_a, src_b,
    output busy, done, result, zero, div_zero
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: single-cycle logic/add ops, iterative mul and unsigned divide
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset_n,
  seq_alu_if.slave bus
);
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt;
  // acc: partial product (MUL) or partial remainder (DIVU/REMU)
  // opa: shifting multiplicand (MUL) or dividend/quotient shifter (DIVU/REMU)
  // opb: shifting multiplier (MUL) or fixed divisor (DIVU/REMU)
  logic [WIDTH-1:0] acc, opa, opb;
  logic [2:0]       op_r;
  logic             divz_r;

  logic             accept, multi_in, div_r;
  logic [WIDTH:0]   add_x, add_y;
  logic             add_inv;
  logic [WIDTH+1:0] add_sum;
  logic [WIDTH-1:0] acc_nxt, opa_nxt, opb_nxt, fin_res, single_res;

  // A start is honoured whenever no iterative op is in flight.
  assign accept   = bus.start && (state != RUN);
  assign multi_in = (bus.alu_op == OP_MUL) || (bus.alu_op == OP_DIVU) || (bus.alu_op == OP_REMU);
  assign div_r    = (op_r == OP_DIVU) || (op_r == OP_REMU);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE, FIN: begin
        bus.done = (state == FIN);
        if (accept) state_nxt = multi_in ? RUN : FIN;
        else        state_nxt = IDLE;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (cnt == WIDTH'(1)) state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand steering for the one shared WIDTH+1 bit adder/subtractor.
  // Outside RUN it serves ADD/SUB/SLT on the raw (sign-extended) inputs so
  // that bit WIDTH is the true sign of a-b for SLT.
  always_comb begin
    add_x   = {bus.src_a[WIDTH-1], bus.src_a};
    add_y   = {bus.src_b[WIDTH-1], bus.src_b};
    add_inv = (bus.alu_op == OP_SUB) || (bus.alu_op == OP_SLT);
    if (state == RUN) begin
      if (div_r) begin
        add_x   = {acc, opa[WIDTH-1]};
        add_y   = {1'b0, opb};
        add_inv = 1'b1;
      end else begin
        add_x   = {1'b0, acc};
        add_y   = {1'b0, opa};
        add_inv = 1'b0;
      end
    end
  end

  // Carry out (bit WIDTH+1) of a subtraction means "no borrow", i.e. x >= y.
  assign add_sum = {1'b0, add_x} + {1'b0, (add_inv ? ~add_y : add_y)}
                 + {{(WIDTH+1){1'b0}}, add_inv};

  // One iteration of shift-add multiply or restoring division. With a zero
  // divisor every trial subtract succeeds, so the quotient fills with ones
  // and the remainder ends up holding the shifted-in dividend.
  always_comb begin
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    if (div_r) begin
      opa_nxt = {opa[WIDTH-2:0], add_sum[WIDTH+1]};
      acc_nxt = add_sum[WIDTH+1] ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
    end else begin
      acc_nxt = opb[0] ? add_sum[WIDTH-1:0] : acc;
      opa_nxt = {opa[WIDTH-2:0], 1'b0};
      opb_nxt = {1'b0, opb[WIDTH-1:1]};
    end
    fin_res = (op_r == OP_DIVU) ? opa_nxt : acc_nxt;
  end

  // Result for the ops that complete in the accept cycle.
  always_comb begin
    single_res = '0;
    case (bus.alu_op)
      OP_AND:         single_res = bus.src_a & bus.src_b;
      OP_OR:          single_res = bus.src_a | bus.src_b;
      OP_ADD, OP_SUB: single_res = add_sum[WIDTH-1:0];
      OP_SLT:         single_res = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
      default:        single_res = '0;
    endcase
  end

  // Operand capture, iteration registers and the held result/flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt          <= '0;
      acc          <= '0;
      opa          <= '0;
      opb          <= '0;
      op_r         <= OP_AND;
      divz_r       <= 1'b0;
      bus.result   <= '0;
      bus.zero     <= 1'b1;
      bus.div_zero <= 1'b0;
    end else if (accept) begin
      op_r <= bus.alu_op;
      if (multi_in) begin
        cnt    <= WIDTH'(WIDTH);
        acc    <= '0;
        opa    <= bus.src_a;
        opb    <= bus.src_b;
        divz_r <= (bus.alu_op != OP_MUL) && (bus.src_b == '0);
      end else begin
        bus.result   <= single_res;
        bus.zero     <= (single_res == '0);
        bus.div_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      acc <= acc_nxt;
      opa <= opa_nxt;
      opb <= opb_nxt;
      cnt <= cnt - WIDTH'(1);
      if (cnt == WIDTH'(1)) begin
        bus.result   <= fin_res;
        bus.zero     <= (fin_res == '0);
        bus.div_zero <= divz_r;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu at WIDTH=32
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         dz;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && bus.done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: actual=1 required=0 at cycle %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_result"}, bus.result, mon_e.res);
          chk({mon_e.name, "_zero"}, bus.zero, mon_e.z);
          chk({mon_e.name, "_div_zero"}, bus.div_zero, mon_e.dz);
          chk({mon_e.name, "_done_cycle"}, cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] want, input logic dz);
    exp_t e;
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      step();
      n++;
    end
    bus.start  = 1'b1;
    bus.alu_op = op;
    bus.src_a  = a;
    bus.src_b  = b;
    e.res  = want;
    e.z    = (want == '0);
    e.dz   = dz;
    e.cyc  = cyc + (((op == 3'd3) || (op == 3'd4) || (op == 3'd5)) ? W + 1 : 1);
    e.name = name;
    sb.push_back(e);
    step();
    bus.start = 1'b0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", sb.size());
    end
  endtask

  initial begin
    int n;
    int base;
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    bus.start  = 1'b0;
    bus.alu_op = 3'd0;
    bus.src_a  = '0;
    bus.src_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_zero", bus.zero, 1);
    chk("reset_div_zero", bus.div_zero, 0);
    reset_n = 1'b1;
    step();

    issue("add_5_7", 3'd2, 5, 7, 12, 0);
    chk("add_busy", bus.busy, 0);
    drain();

    issue("mul_m3_7", 3'd3, -3, 7, 32'hFFFF_FFEB, 0);
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    chk("mul_busy_cycles", n, 32);
    drain();

    issue("divu_100_7", 3'd4, 100, 7, 14, 0);
    issue("remu_100_7", 3'd5, 100, 7, 2, 0);
    issue("divu_5_0", 3'd4, 5, 0, 32'hFFFF_FFFF, 1);
    issue("remu_5_0", 3'd5, 5, 0, 5, 1);
    issue("add_after_dz", 3'd2, 1, 2, 3, 0);
    issue("sub_9_9", 3'd6, 9, 9, 0, 0);
    issue("slt_m1_1", 3'd7, -1, 1, 1, 0);
    issue("slt_1_1", 3'd7, 1, 1, 0, 0);
    issue("slt_1_m1", 3'd7, 1, -1, 0, 0);
    issue("slt_min_max", 3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0);
    issue("and", 3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0);
    issue("or", 3'd1, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 0);
    issue("add_wrap", 3'd2, 32'hFFFF_FFFF, 1, 0, 0);
    issue("sub_wrap", 3'd6, 0, 1, 32'hFFFF_FFFF, 0);
    issue("mul_overflow", 3'd3, 32'h0001_0000, 32'h0001_0000, 0, 0);
    issue("mul_shift", 3'd3, 32'h0001_2345, 32'h10, 32'h0012_3450, 0);
    issue("divu_max_1", 3'd4, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0);
    issue("divu_max_msb", 3'd4, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    issue("remu_max_msb", 3'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    issue("remu_msb_3", 3'd5, 32'h8000_0000, 3, 2, 0);
    issue("divu_7_100", 3'd4, 7, 100, 0, 0);
    drain();

    // A start raised mid-MUL must be ignored.
    issue("mul_ign", 3'd3, 6, 7, 42, 0);
    base = done_cnt;
    repeat (4) step();
    bus.start  = 1'b1;
    bus.alu_op = 3'd2;
    bus.src_a  = 100;
    bus.src_b  = 200;
    step();
    bus.start = 1'b0;
    drain();
    repeat (5) step();
    chk("mul_ign_done_count", done_cnt - base, 1);

    // Reset in the middle of a DIVU, with a start asserted during reset.
    issue("divu_rst", 3'd4, 100, 7, 14, 0);
    repeat (9) step();
    reset_n    = 1'b0;
    bus.start  = 1'b1;
    bus.alu_op = 3'd2;
    bus.src_a  = 1;
    bus.src_b  = 1;
    void'(sb.pop_back());
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_div_zero", bus.div_zero, 0);
    reset_n   = 1'b1;
    bus.start = 1'b0;
    base = done_cnt;
    repeat (40) step();
    chk("rst_no_done", done_cnt - base, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
